// File: rtl/z_pkg.sv
// -----------------------------------------------------------------------------
// z_pkg
// Shared definitions for the depth-test stage: state encoding, default depth
// width, default clear value, counter width and a saturating-increment helper.
// -----------------------------------------------------------------------------
package z_pkg;

  // Default depth width; must match the z-buffer data width.
  localparam int unsigned Z_W_DEF = 16;

  // Depth written by the clear sweep: all ones is the farthest depth.
  localparam logic [Z_W_DEF-1:0] CLEAR_VAL_DEF = {Z_W_DEF{1'b1}};

  // Statistics counter width.
  localparam int unsigned CNT_W = 32;

  // FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_CMP  = 3'd2;
  localparam state_t ST_OUT  = 3'd3;
  localparam state_t ST_CLR  = 3'd4;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/z_clear_sweep.sv
// -----------------------------------------------------------------------------
// z_clear_sweep
// Address generator for the z-buffer clear. Once started, it walks the index
// from 0 to SIZE-1, one entry per cycle, holding busy high for exactly SIZE
// cycles, then pulses done for one cycle. A start request while busy is
// ignored.
//
// Ports
//   clk_i    in   1       system clock
//   rst_i    in   1       asynchronous, active-high reset (aborts any sweep)
//   start_i  in   1       start request, honoured only while not busy
//   idx_o    out  ADDR_W  entry being cleared this cycle
//   busy_o   out  1       sweep in progress (registered)
//   done_o   out  1       one-cycle pulse after the last entry (registered)
//   last_o   out  1       this cycle writes the final entry
// -----------------------------------------------------------------------------
module z_clear_sweep
  import z_pkg::*;
#(
  parameter int unsigned SIZE   = 49152,
  parameter int unsigned ADDR_W = $clog2(SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              done_q;
  logic              last_s;

  // Final entry of the sweep is being written this cycle.
  always_comb begin
    last_s = busy_q & (idx_q == LAST_IDX);
  end

  // Index counter with busy/done generation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= {ADDR_W{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        if (last_s) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          idx_q  <= {ADDR_W{1'b0}};
        end else begin
          idx_q  <= idx_q + IDX_ONE;
        end
      end else if (start_i) begin
        busy_q <= 1'b1;
        idx_q  <= {ADDR_W{1'b0}};
      end else begin
        idx_q  <= idx_q;
      end
    end
  end

  assign idx_o  = idx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign last_o = last_s;

endmodule

// File: rtl/z_test_unit.sv
// -----------------------------------------------------------------------------
// z_test_unit
// Per-fragment depth test stage. Owns the single port of the z-buffer BRAM.
// A fragment accepted in IDLE has its address registered onto the z-buffer
// port (RD); the stored depth comes back the cycle after (CMP) and is compared
// against the fragment depth. A strictly nearer fragment writes its depth in
// that same CMP cycle and is then offered downstream (OUT) until accepted; any
// other fragment is dropped. A clear request sweeps every entry to CLEAR_VAL.
//
// Ports
//   clk_i          in   1        system clock
//   rst_i          in   1        asynchronous, active-high reset
//   clear_start_i  in   1        start clear sweep (honoured only in IDLE)
//   clear_busy_o   out  1        sweep running
//   clear_done_o   out  1        one-cycle pulse after the last clear write
//   frag_valid_i   in   1        upstream fragment valid
//   frag_ready_o   out  1        upstream ready
//   frag_addr_i    in   ADDR_W   fragment pixel address
//   frag_z_i       in   Z_W      fragment depth (smaller = nearer)
//   frag_color_i   in   COLOR_W  fragment colour
//   out_valid_o    out  1        passed fragment valid, held until out_ready_i
//   out_ready_i    in   1        downstream ready
//   out_addr_o     out  ADDR_W   passed pixel address
//   out_color_o    out  COLOR_W  passed colour
//   zb_we_o        out  1        z-buffer write enable
//   zb_addr_o      out  ADDR_W   z-buffer address
//   zb_data_o      out  Z_W      z-buffer write data
//   zb_q_i         in   Z_W      z-buffer read data (one cycle after address)
//   pass_cnt_o     out  32       passed fragments, saturating
//   fail_cnt_o     out  32       rejected fragments, saturating
// -----------------------------------------------------------------------------
module z_test_unit
  import z_pkg::*;
#(
  parameter int unsigned     SIZE      = 49152,
  parameter int unsigned     ADDR_W    = $clog2(SIZE),
  parameter int unsigned     Z_W       = Z_W_DEF,
  parameter int unsigned     COLOR_W   = 16,
  parameter logic [Z_W-1:0]  CLEAR_VAL = {Z_W{1'b1}}
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_start_i,
  output logic               clear_busy_o,
  output logic               clear_done_o,
  input  logic               frag_valid_i,
  output logic               frag_ready_o,
  input  logic [ADDR_W-1:0]  frag_addr_i,
  input  logic [Z_W-1:0]     frag_z_i,
  input  logic [COLOR_W-1:0] frag_color_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ADDR_W-1:0]  out_addr_o,
  output logic [COLOR_W-1:0] out_color_o,
  output logic               zb_we_o,
  output logic [ADDR_W-1:0]  zb_addr_o,
  output logic [Z_W-1:0]     zb_data_o,
  input  logic [Z_W-1:0]     zb_q_i,
  output logic [CNT_W-1:0]   pass_cnt_o,
  output logic [CNT_W-1:0]   fail_cnt_o
);

  state_t             state_q;
  state_t             state_d;

  logic [ADDR_W-1:0]  addr_q;
  logic [Z_W-1:0]     frag_z_q;
  logic [COLOR_W-1:0] color_q;
  logic [ADDR_W-1:0]  zb_addr_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   pass_cnt_q;
  logic [CNT_W-1:0]   fail_cnt_q;

  logic               frag_ready_s;
  logic               frag_fire_s;
  logic               z_pass_s;
  logic               zb_we_s;
  logic [ADDR_W-1:0]  zb_addr_s;
  logic [Z_W-1:0]     zb_data_s;

  logic               sw_start_s;
  logic [ADDR_W-1:0]  sw_idx_s;
  logic               sw_busy_s;
  logic               sw_done_s;
  logic               sw_last_s;

  // Handshake, clear launch and depth compare (unsigned, strict: ties lose).
  always_comb begin
    frag_fire_s = frag_valid_i & frag_ready_s;
    sw_start_s  = (state_q == ST_IDLE) & clear_start_i;
    z_pass_s    = (frag_z_q < zb_q_i);
  end

  z_clear_sweep #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (sw_start_s),
    .idx_o   (sw_idx_s),
    .busy_o  (sw_busy_s),
    .done_o  (sw_done_s),
    .last_o  (sw_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a clear request beats a simultaneous fragment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start_i) begin
          state_d = ST_CLR;
        end else if (frag_valid_i) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_CMP;
      end
      ST_CMP: begin
        if (z_pass_s) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_CLR: begin
        if (sw_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: upstream ready and the z-buffer port. The write in CMP is
  // combinational on zb_q_i so it lands in the compare cycle itself.
  always_comb begin
    frag_ready_s = 1'b0;
    zb_we_s      = 1'b0;
    zb_addr_s    = zb_addr_q;
    zb_data_s    = frag_z_q;
    case (state_q)
      ST_IDLE: begin
        frag_ready_s = ~clear_start_i;
      end
      ST_RD: begin
        zb_we_s = 1'b0;
      end
      ST_CMP: begin
        if (z_pass_s) begin
          zb_we_s = 1'b1;
        end else begin
          zb_we_s = 1'b0;
        end
      end
      ST_OUT: begin
        zb_we_s = 1'b0;
      end
      ST_CLR: begin
        zb_we_s   = 1'b1;
        zb_addr_s = sw_idx_s;
        zb_data_s = CLEAR_VAL;
      end
      default: begin
        frag_ready_s = 1'b0;
      end
    endcase
  end

  // Fragment latch and z-buffer address holding register. The address tracks
  // the sweep index during CLR so it keeps the last value once the sweep ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= {ADDR_W{1'b0}};
      frag_z_q  <= {Z_W{1'b0}};
      color_q   <= {COLOR_W{1'b0}};
      zb_addr_q <= {ADDR_W{1'b0}};
    end else if (frag_fire_s) begin
      addr_q    <= frag_addr_i;
      frag_z_q  <= frag_z_i;
      color_q   <= frag_color_i;
      zb_addr_q <= frag_addr_i;
    end else if (state_q == ST_CLR) begin
      zb_addr_q <= sw_idx_s;
    end else begin
      zb_addr_q <= zb_addr_q;
    end
  end

  // Downstream valid: high exactly while the FSM sits in OUT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_d == ST_OUT);
    end
  end

  // Pass/fail statistics, updated once per compare.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_cnt_q <= {CNT_W{1'b0}};
      fail_cnt_q <= {CNT_W{1'b0}};
    end else if (state_q == ST_CMP) begin
      if (z_pass_s) begin
        pass_cnt_q <= sat_inc(pass_cnt_q);
      end else begin
        fail_cnt_q <= sat_inc(fail_cnt_q);
      end
    end else begin
      pass_cnt_q <= pass_cnt_q;
      fail_cnt_q <= fail_cnt_q;
    end
  end

  // Ready is forced low while reset is held so nothing looks accepted.
  assign frag_ready_o = frag_ready_s & ~rst_i;
  assign clear_busy_o = sw_busy_s;
  assign clear_done_o = sw_done_s;
  assign out_valid_o  = out_valid_q;
  assign out_addr_o   = addr_q;
  assign out_color_o  = color_q;
  assign zb_we_o      = zb_we_s;
  assign zb_addr_o    = zb_addr_s;
  assign zb_data_o    = zb_data_s;
  assign pass_cnt_o   = pass_cnt_q;
  assign fail_cnt_o   = fail_cnt_q;

endmodule

// File: tb/tb_z_test_unit.sv
module tb_z_test_unit;

  localparam int SIZE    = 512;
  localparam int ADDR_W  = $clog2(SIZE);
  localparam int Z_W     = 16;
  localparam int COLOR_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear_start = 1'b0;
  logic               clear_busy, clear_done;
  logic               frag_valid = 1'b0;
  logic               frag_ready;
  logic [ADDR_W-1:0]  frag_addr = '0;
  logic [Z_W-1:0]     frag_z = '0;
  logic [COLOR_W-1:0] frag_color = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [ADDR_W-1:0]  out_addr;
  logic [COLOR_W-1:0] out_color;
  logic               zb_we;
  logic [ADDR_W-1:0]  zb_addr;
  logic [Z_W-1:0]     zb_data;
  logic [Z_W-1:0]     zb_q;
  logic [31:0]        pass_cnt, fail_cnt;

  always #5 clk = ~clk;

  z_test_unit #(.SIZE(SIZE)) dut (
    .clk_i(clk), .rst_i(rst),
    .clear_start_i(clear_start), .clear_busy_o(clear_busy), .clear_done_o(clear_done),
    .frag_valid_i(frag_valid), .frag_ready_o(frag_ready),
    .frag_addr_i(frag_addr), .frag_z_i(frag_z), .frag_color_i(frag_color),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_color_o(out_color),
    .zb_we_o(zb_we), .zb_addr_o(zb_addr), .zb_data_o(zb_data), .zb_q_i(zb_q),
    .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt)
  );

  // z-buffer: single port, registered read-first output; preload fills a pattern.
  logic [Z_W-1:0] mem [SIZE];
  logic           preload = 1'b0;
  always_ff @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= 16'h5A00 + 16'(i);
    end else if (zb_we) begin
      mem[zb_addr] <= zb_data;
    end
    zb_q <= mem[zb_addr];
  end

  int tests = 0;
  int fails = 0;
  int exp_pass_n = 0;
  int exp_fail_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [Z_W-1:0]     z;
    logic [COLOR_W-1:0] col;
    logic               pass;
    logic [Z_W-1:0]     mem_after;
  } vec_t;

  vec_t vecs[8];

  // Wait (bounded) at negedges until frag_ready is high.
  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (frag_ready) break;
      @(negedge clk);
    end
    check("accept_ready", frag_ready, 1);
  endtask

  // Called at the negedge preceding the accepting posedge.
  task automatic frag_finish(input logic [ADDR_W-1:0] a, input logic [Z_W-1:0] z,
                             input logic [COLOR_W-1:0] c, input logic pass,
                             input logic [Z_W-1:0] exp_mem);
    @(posedge clk);
    @(negedge clk);            // RD
    frag_valid = 1'b0;
    check("rd_out_valid", out_valid, 0);
    check("rd_we", zb_we, 0);
    @(negedge clk);            // CMP
    check("cmp_we", zb_we, pass);
    if (pass) begin
      check("cmp_addr", zb_addr, a);
      check("cmp_data", zb_data, z);
      exp_pass_n++;
    end else begin
      exp_fail_n++;
    end
    @(negedge clk);            // OUT (pass) or IDLE (fail)
    check("out_valid", out_valid, pass);
    if (pass) begin
      check("out_addr", out_addr, a);
      check("out_color", out_color, c);
    end
    check("pass_cnt", pass_cnt, exp_pass_n);
    check("fail_cnt", fail_cnt, exp_fail_n);
    check("mem_after", mem[a], exp_mem);
    if (pass && out_ready) begin
      @(negedge clk);
      check("out_valid_drop", out_valid, 0);
    end
  endtask

  task automatic apply_frag(input logic [ADDR_W-1:0] a, input logic [Z_W-1:0] z,
                            input logic [COLOR_W-1:0] c, input logic pass,
                            input logic [Z_W-1:0] exp_mem);
    frag_valid = 1'b1; frag_addr = a; frag_z = z; frag_color = c;
    wait_ready();
    frag_finish(a, z, c, pass, exp_mem);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_n, done_n, bad, errs;
    logic [ADDR_W-1:0]  h_addr;
    logic [COLOR_W-1:0] h_col;

    vecs[0] = '{ADDR_W'(5),   16'h1000, 16'hF800, 1'b1, 16'h1000};
    vecs[1] = '{ADDR_W'(5),   16'h1000, 16'h07E0, 1'b0, 16'h1000};
    vecs[2] = '{ADDR_W'(5),   16'h0FFF, 16'h001F, 1'b1, 16'h0FFF};
    vecs[3] = '{ADDR_W'(511), 16'hFFFE, 16'hAAAA, 1'b1, 16'hFFFE};
    vecs[4] = '{ADDR_W'(0),   16'hFFFF, 16'h5555, 1'b0, 16'hFFFF};
    vecs[5] = '{ADDR_W'(0),   16'h0000, 16'h0001, 1'b1, 16'h0000};
    vecs[6] = '{ADDR_W'(0),   16'h0000, 16'h0002, 1'b0, 16'h0000};
    vecs[7] = '{ADDR_W'(300), 16'h8000, 16'hBEEF, 1'b1, 16'h8000};

    // Reset state
    #1;
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_ready", frag_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_we", zb_we, 0);
    check("rst_zb_addr", zb_addr, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", frag_ready, 1);

    // Test 1: full clear, with an ignored re-start mid-sweep
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    busy_n = 0; done_n = 0; bad = 0;
    for (int k = 0; k < SIZE + 8; k++) begin
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
      if (clear_busy && (frag_ready || !zb_we || zb_addr != ADDR_W'(k))) bad++;
      clear_start = (k == 40);
      @(negedge clk);
    end
    clear_start = 1'b0;
    check("clr_busy_cycles", busy_n, SIZE);
    check("clr_done_pulses", done_n, 1);
    check("clr_port_bad", bad, 0);
    errs = 0;
    for (int i = 0; i < SIZE; i++) if (mem[i] !== 16'hFFFF) errs++;
    check("clr_mem_ffff", errs, 0);

    // Tests 2,3 and boundary vectors
    foreach (vecs[i]) apply_frag(vecs[i].addr, vecs[i].z, vecs[i].col, vecs[i].pass, vecs[i].mem_after);

    // Test 4: downstream stall for 10 cycles in OUT
    out_ready = 1'b0;
    frag_valid = 1'b1; frag_addr = ADDR_W'(7); frag_z = 16'h0100; frag_color = 16'h1234;
    wait_ready();
    @(posedge clk); @(negedge clk);
    frag_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    exp_pass_n++;
    check("stall_out_valid", out_valid, 1);
    h_addr = out_addr; h_col = out_color;
    check("stall_addr", h_addr, 7);
    check("stall_col", h_col, 16'h1234);
    errs = 0;
    frag_valid = 1'b1; frag_addr = ADDR_W'(8); frag_z = 16'h0001;
    for (int k = 0; k < 10; k++) begin
      if (!out_valid || out_addr != h_addr || out_color != h_col || frag_ready || zb_we) errs++;
      @(negedge clk);
    end
    check("stall_stable", errs, 0);
    frag_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release", out_valid, 0);
    check("stall_mem", mem[7], 16'h0100);
    check("stall_mem8", mem[8], 16'hFFFF);
    check("stall_pass_cnt", pass_cnt, exp_pass_n);

    // Test 5: clear and fragment in the same IDLE cycle
    clear_start = 1'b1;
    frag_valid = 1'b1; frag_addr = ADDR_W'(9); frag_z = 16'h0200; frag_color = 16'h0F0F;
    #1;
    check("race_ready", frag_ready, 0);
    @(negedge clk);
    clear_start = 1'b0;
    busy_n = 0; bad = 0;
    for (int k = 0; k < SIZE + 10; k++) begin
      if (clear_done) break;
      if (clear_busy) busy_n++;
      if (clear_busy && frag_ready) bad++;
      @(negedge clk);
    end
    check("race_done", clear_done, 1);
    check("race_busy_cycles", busy_n, SIZE);
    check("race_ready_in_clr", bad, 0);
    check("race_mem5", mem[5], 16'hFFFF);
    check("race_ready_after", frag_ready, 1);
    frag_finish(ADDR_W'(9), 16'h0200, 16'h0F0F, 1'b1, 16'h0200);

    // Reset while a fragment waits in OUT
    out_ready = 1'b0;
    apply_frag(ADDR_W'(20), 16'h0300, 16'h00FF, 1'b1, 16'h0300);
    #2 rst = 1'b1;
    #1;
    check("rst_out_drop", out_valid, 0);
    exp_pass_n = 0; exp_fail_n = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_out_cnt", pass_cnt, 0);

    // Test 6: reset at idx 100 of the sweep
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      if (clear_busy && zb_addr == ADDR_W'(100)) break;
      @(negedge clk);
    end
    check("abort_found_idx", zb_addr, 100);
    rst = 1'b1;
    #1;
    check("abort_busy", clear_busy, 0);
    check("abort_we", zb_we, 0);
    check("abort_zb_addr", zb_addr, 0);
    check("abort_zb_data", zb_data, 0);
    check("abort_ready", frag_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 6; k++) begin
      if (clear_done || clear_busy || zb_we) errs++;
      @(negedge clk);
    end
    check("abort_no_done", errs, 0);
    check("abort_idle_ready", frag_ready, 1);
    check("abort_mem0", mem[0], 16'hFFFF);
    check("abort_mem99", mem[99], 16'hFFFF);
    check("abort_mem101", mem[101], 16'h5A65);
    check("abort_mem_last", mem[SIZE-1], 16'h5BFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
